// File: rtl/regwb_pkg.sv
// Shared definitions for the register-file write-back arbiter:
// default widths, source-index encoding and the write-back request record.
package regwb_pkg;

  localparam int REGWB_ADDR_W = 5;
  localparam int REGWB_DATA_W = 32;

  // Bit position of each producer in the req/gnt vectors
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  typedef struct packed {
    logic                    valid;
    logic [REGWB_ADDR_W-1:0] addr;
    logic [REGWB_DATA_W-1:0] data;
  } wb_req_t;

  // Round-robin pick between two requesters; last_grant names the source
  // that won most recently, so contention goes to the other one.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational from req and the
// registered last_grant; last_grant only moves when someone is granted.
// Reset leaves last_grant=1 so source 0 wins the first contention.
module rr_arb2
  import regwb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  // Combinational one-hot (or zero) grant
  always_comb begin
    gnt = rr_pick(req, last_grant);
  end

  // Remember the winner so the other source gets the next contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[SRC_MEM];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the register file.
// Source 0 (ALU) and source 1 (memory load) share the single write port
// we3/a3/wd3, which is registered one cycle after the grant. A pending bit
// per register lets decode stall on operands whose producer is in flight.
// Optional feature macro: REGWB_FWD_EN adds fwd_hit1/fwd_hit2/fwd_data so
// decode can take the write-port data instead of stalling in the write cycle.
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter int ADDR_W = REGWB_ADDR_W,
  parameter int DATA_W = REGWB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_busy1,
  output logic              rd_busy2
`ifdef REGWB_FWD_EN
  ,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]      req;
  logic [1:0]      gnt;
  wb_req_t         sel_req;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Requests are masked during reset so both readies stay low
  assign req = {s1_valid, s0_valid} & {2{rst}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign s0_ready = gnt[SRC_ALU];
  assign s1_ready = gnt[SRC_MEM];

  // Select the granted producer's address/data for the write stage
  always_comb begin
    sel_req.valid = |gnt;
    sel_req.addr  = s0_addr;
    sel_req.data  = s0_data;
    if (gnt[SRC_MEM]) begin
      sel_req.addr = s1_addr;
      sel_req.data = s1_data;
    end
  end

  // ---- grant -> write port boundary ----
  // Register the granted write; address/data hold when nothing is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= sel_req.valid;
      if (sel_req.valid) begin
        a3  <= sel_req.addr;
        wd3 <= sel_req.data;
      end
    end
  end

  // Next scoreboard: clear the register being written, then apply the new
  // destination so a fresh producer to the same register stays pending
  always_comb begin
    pending_nxt = pending;
    if (we3) begin
      pending_nxt[a3] = 1'b0;
    end
    if (busy_set) begin
      pending_nxt[busy_addr] = 1'b1;
    end
  end

  // ---- scoreboard register ----
  // One pending bit per register, visible to decode one cycle after busy_set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

`ifdef REGWB_FWD_EN
  // A register being written this cycle is served from the write port
  assign fwd_hit1 = we3 && (a3 == rd_addr1);
  assign fwd_hit2 = we3 && (a3 == rd_addr2);
  assign fwd_data = wd3;
  assign rd_busy1 = pending[rd_addr1] & ~fwd_hit1;
  assign rd_busy2 = pending[rd_addr2] & ~fwd_hit2;
`else
  // Without forwarding the operand is only readable after the write lands
  assign rd_busy1 = pending[rd_addr1];
  assign rd_busy2 = pending[rd_addr2];
`endif

endmodule
